tft_lcd_timing_gen: RTL and testbench
=====================================

Name: tft_lcd_timing_gen

Overview:
- Raster timing generator for the 800x480 TFT panel path.
- Produces pixel clock, h/v position counters, DE, HSYNC, VSYNC and panel enable.
- Sits directly upstream of the RGB colour/pattern stage, which registers pixel data from counter_h/counter_v while disp_den is high.
- Sequences the panel on and off in whole frames, driven by the enable input.

Parameters:
- CLK_DIV, 2: clk cycles per pixel; must be even and >=2.
- H_TOTAL, 1056: pixel ticks per line.
- H_SYNC_W, 20: HSYNC low width, in ticks.
- H_DE_START, 210: first active counter_h.
- H_ACTIVE, 800: active pixels per line.
- V_TOTAL, 525: lines per frame.
- V_SYNC_W, 10: VSYNC low width, in lines.
- V_DE_START, 22: first active counter_v.
- V_ACTIVE, 480: active lines per frame.
- PWR_FRAMES, 2: blank frames emitted before DE is enabled and after disable is requested.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  request panel on (level).
- counter_h  out  11  horizontal position, 0..H_TOTAL-1.
- counter_v  out  10  vertical position, 0..V_TOTAL-1.
- disp_clk  out  1  pixel clock to panel.
- disp_den  out  1  data enable.
- disp_hsync  out  1  active-low horizontal sync.
- disp_vsync  out  1  active-low vertical sync.
- disp_enb  out  1  panel enable / backlight gate.
- frame_start  out  1  one-clk pulse when counter_h and counter_v wrap to 0,0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0 except disp_hsync=1 and disp_vsync=1. State is IDLE; div_cnt, frame counter and counters are 0.
- Divider: div_cnt runs 0..CLK_DIV-1 whenever not IDLE.
  - disp_clk is registered and is 1 while div_cnt < CLK_DIV/2.
  - tick = (div_cnt == CLK_DIV-1).
- Counters advance only on tick:
  - counter_h increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, counter_v increments and wraps from V_TOTAL-1 to 0.
- Syncs, DE and frame_start are registered and update in the same clk as the counter change (0 latency relative to the counters).
- disp_hsync = 0 iff counter_h < H_SYNC_W.
- disp_vsync = 0 iff counter_v < V_SYNC_W.
- Raw DE = counter_h in [H_DE_START, H_DE_START+H_ACTIVE) and counter_v in [V_DE_START, V_DE_START+V_ACTIVE).
- disp_den = raw DE only in ACTIVE; otherwise 0.
- FSM:
  - IDLE: counters held at 0, disp_clk=0, syncs high, disp_enb=0.
    - enable=1 → PWR_UP next clk.
  - PWR_UP: timing runs; disp_enb=1; DE forced 0; frame counter increments at each frame_start.
    - After PWR_FRAMES frame_starts → ACTIVE, so DE first appears at the start of a frame.
    - enable=0 → PWR_DOWN.
  - ACTIVE: full timing.
    - enable=0 is latched; the current frame completes. At the next frame_start → PWR_DOWN; DE is never truncated mid-frame.
  - PWR_DOWN: timing runs, DE forced 0, disp_enb stays 1 for PWR_FRAMES frames, then → IDLE (disp_enb=0, counters cleared).
    - enable=1 during PWR_DOWN is ignored until IDLE is reached; from IDLE it restarts PWR_UP next clk.
- Frame counter: clears on every state change; sized for PWR_FRAMES up to 255.
- Boundary:
  - PWR_FRAMES=0 → PWR_UP goes to ACTIVE at the first frame_start.
  - Simultaneous counter_h and counter_v wrap produces exactly one frame_start.
  - rst mid-frame returns everything to reset values immediately (asynchronous).
- Widths: counters compare unsigned; parameter sums must fit 11/10 bits (not checked in RTL).

Optional Feature:
- Macro: TFT_TIMING_LINE_IRQ_EN.
- When defined:
  - Adds parameter LINE_IRQ (default 480) and output port line_irq (1 bit).
  - line_irq pulses for one clk on the tick where counter_v becomes LINE_IRQ and counter_h becomes 0.
  - Pulses only in ACTIVE; reset value 0.
- When undefined: no port, no parameter, no logic.

Test Plan:
- Default parameters, rst, then enable=1 held:
  - disp_clk period = 2 clk.
  - disp_den stays 0 for the first 2 frames; first DE at counter_h=210, counter_v=22 of frame 3.
  - Exactly 800 DE ticks per line and 480 DE lines per frame.
- Sync widths:
  - disp_hsync low for 20 ticks per 1056-tick line.
  - disp_vsync low for 10 lines per 525-line frame.
  - frame_start period = 1056*525*2 = 1,108,800 clk.
- Deassert enable at counter_v=100 in ACTIVE:
  - DE continues to the end of the frame (line 501).
  - Then 2 blank frames with disp_enb=1.
  - Then IDLE: disp_enb=0, busy=0, counters 0.
- Assert rst mid-line (counter_h=500):
  - All outputs return to reset values within the same clk, without waiting for a clk edge.
  - Sequence restarts from PWR_UP after rst release with enable=1.
- Small config (CLK_DIV=4, H_TOTAL=16, V_TOTAL=8, PWR_FRAMES=0):
  - Counter wrap 15→0 increments counter_v.
  - Wrap 7→0 gives a single frame_start.
  - ACTIVE entered at the first frame_start.
- With TFT_TIMING_LINE_IRQ_EN and LINE_IRQ=480:
  - One line_irq pulse per frame at counter_v=480, counter_h=0 in ACTIVE.
  - No pulses in PWR_UP or PWR_DOWN.

Source files
------------

// File: rtl/tft_lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// tft_lcd_timing_gen
//
// Raster timing generator for the 800x480 TFT panel path. It produces the pixel
// clock, the h/v position counters, DE, HSYNC, VSYNC and the panel enable. It
// also powers the panel up and down in whole frames, following the enable level.
//
// The FSM steps IDLE -> PWR_UP -> ACTIVE -> PWR_DOWN -> IDLE. DE is only let
// through in ACTIVE. ACTIVE is entered and left only on a frame boundary, so a
// frame of data is never cut short.
//
// Optional feature: define TFT_TIMING_LINE_IRQ_EN to add parameter LINE_IRQ and
// output line_irq. line_irq is a one-clk pulse in ACTIVE when the raster enters
// line LINE_IRQ.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   enable       panel-on request (level)
//   counter_h    horizontal position, 0..H_TOTAL-1
//   counter_v    vertical position, 0..V_TOTAL-1
//   disp_clk     pixel clock to the panel
//   disp_den     data enable
//   disp_hsync   horizontal sync, active low
//   disp_vsync   vertical sync, active low
//   disp_enb     panel enable / backlight gate
//   frame_start  one-clk pulse when the counters wrap to 0,0
//   busy         high in any state other than IDLE
//   line_irq     (optional) line interrupt pulse
// -----------------------------------------------------------------------------
module tft_lcd_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_TOTAL    = 1056,
  parameter int H_SYNC_W   = 20,
  parameter int H_DE_START = 210,
  parameter int H_ACTIVE   = 800,
  parameter int V_TOTAL    = 525,
  parameter int V_SYNC_W   = 10,
  parameter int V_DE_START = 22,
  parameter int V_ACTIVE   = 480,
  parameter int PWR_FRAMES = 2
`ifdef TFT_TIMING_LINE_IRQ_EN
  ,
  parameter int LINE_IRQ   = 480
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [10:0] counter_h,
  output logic [9:0]  counter_v,
  output logic        disp_clk,
  output logic        disp_den,
  output logic        disp_hsync,
  output logic        disp_vsync,
  output logic        disp_enb,
  output logic        frame_start,
  output logic        busy
`ifdef TFT_TIMING_LINE_IRQ_EN
  ,
  output logic        line_irq
`endif
);

  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [10:0]   H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0]   H_SYNC   = 11'(H_SYNC_W);
  localparam logic [10:0]   H_DE_S   = 11'(H_DE_START);
  localparam logic [10:0]   H_DE_E   = 11'(H_DE_START + H_ACTIVE);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_SYNC   = 10'(V_SYNC_W);
  localparam logic [9:0]    V_DE_S   = 10'(V_DE_START);
  localparam logic [9:0]    V_DE_E   = 10'(V_DE_START + V_ACTIVE);
  localparam logic [8:0]    PWR_N    = 9'(PWR_FRAMES);

  typedef enum logic [1:0] {IDLE, PWR_UP, ACTIVE, PWR_DOWN} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [10:0]     counter_h_q, counter_h_d;
  logic [9:0]      counter_v_q, counter_v_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            stop_q, stop_d;
  logic            disp_clk_q, disp_clk_d;
  logic            den_q, den_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            enb_q, enb_d;
  logic            frame_start_q, frame_start_d;
  logic            tick, h_wrap, frame_wrap, frames_done, run_d;
`ifdef TFT_TIMING_LINE_IRQ_EN
  localparam logic [9:0] V_IRQ = 10'(LINE_IRQ);
  logic line_irq_q, line_irq_d;
`endif

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statements can leave it unassigned and infer a latch.
    state_d     = state_q;
    stop_d      = stop_q;
    frame_cnt_d = frame_cnt_q;
    div_cnt_d   = div_cnt_q;
    counter_h_d = counter_h_q;
    counter_v_d = counter_v_q;

    tick        = (state_q != IDLE) && (div_cnt_q == DIV_LAST);
    h_wrap      = tick && (counter_h_q == H_LAST);
    frame_wrap  = h_wrap && (counter_v_q == V_LAST);
    // Nine bits, so that PWR_FRAMES = 255 does not overflow the compare.
    frames_done = ({1'b0, frame_cnt_q} + 9'd1) >= PWR_N;

    case (state_q)
      IDLE:     if (enable) state_d = PWR_UP;
      PWR_UP: begin
        if (!enable)                        state_d = PWR_DOWN;
        else if (frame_wrap && frames_done) state_d = ACTIVE;
      end
      ACTIVE: begin
        // Remember a drop of enable, but let the current frame finish.
        stop_d = stop_q || !enable;
        if (frame_wrap && (stop_q || !enable)) state_d = PWR_DOWN;
      end
      PWR_DOWN: if (frame_wrap && frames_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      frame_cnt_d = '0;
      stop_d      = 1'b0;
    end else if (frame_wrap) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    if ((state_q == IDLE) || tick) div_cnt_d = '0;
    else                           div_cnt_d = div_cnt_q + 1'b1;

    if (state_d == IDLE) begin
      counter_h_d = '0;
      counter_v_d = '0;
    end else if (tick) begin
      counter_h_d = h_wrap ? 11'd0 : counter_h_q + 11'd1;
      if (h_wrap) counter_v_d = (counter_v_q == V_LAST) ? 10'd0 : counter_v_q + 10'd1;
    end

    // The outputs are decoded from the next-state counters, so each registered
    // output changes in the same clk as the counters it describes.
    run_d         = (state_d != IDLE);
    disp_clk_d    = run_d && (div_cnt_d < DIV_HALF);
    hsync_d       = !run_d || (counter_h_d >= H_SYNC);
    vsync_d       = !run_d || (counter_v_d >= V_SYNC);
    den_d         = (state_d == ACTIVE) &&
                    (counter_h_d >= H_DE_S) && (counter_h_d < H_DE_E) &&
                    (counter_v_d >= V_DE_S) && (counter_v_d < V_DE_E);
    enb_d         = run_d;
    frame_start_d = frame_wrap;
`ifdef TFT_TIMING_LINE_IRQ_EN
    line_irq_d    = h_wrap && (counter_v_d == V_IRQ) && (state_d == ACTIVE);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      stop_q        <= 1'b0;
      frame_cnt_q   <= '0;
      div_cnt_q     <= '0;
      counter_h_q   <= '0;
      counter_v_q   <= '0;
      disp_clk_q    <= 1'b0;
      den_q         <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      enb_q         <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef TFT_TIMING_LINE_IRQ_EN
      line_irq_q    <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments, so every flop
      // samples the values from before the edge, whatever order these lines are in.
      state_q       <= state_d;
      stop_q        <= stop_d;
      frame_cnt_q   <= frame_cnt_d;
      div_cnt_q     <= div_cnt_d;
      counter_h_q   <= counter_h_d;
      counter_v_q   <= counter_v_d;
      disp_clk_q    <= disp_clk_d;
      den_q         <= den_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      enb_q         <= enb_d;
      frame_start_q <= frame_start_d;
`ifdef TFT_TIMING_LINE_IRQ_EN
      line_irq_q    <= line_irq_d;
`endif
    end
  end

  assign counter_h   = counter_h_q;
  assign counter_v   = counter_v_q;
  assign disp_clk    = disp_clk_q;
  assign disp_den    = den_q;
  assign disp_hsync  = hsync_q;
  assign disp_vsync  = vsync_q;
  assign disp_enb    = enb_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q != IDLE);
`ifdef TFT_TIMING_LINE_IRQ_EN
  assign line_irq    = line_irq_q;
`endif

endmodule

// File: tb/tb_tft_lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_tft_lcd_timing_gen
//
// Directed bench for tft_lcd_timing_gen, using two reduced raster configs.
//   u_dut_a : CLK_DIV=2, 16x8 raster, PWR_FRAMES=2 (one frame = 256 clk)
//   u_dut_b : CLK_DIV=4, 16x8 raster, PWR_FRAMES=0 (one frame = 512 clk)
// Both configs use H_SYNC_W=2, H_DE_START=4, H_ACTIVE=8, V_SYNC_W=1,
// V_DE_START=2, V_ACTIVE=4. With the line interrupt built in, u_dut_a uses
// LINE_IRQ=5.
//
// Outputs are sampled on the falling edge. Time is counted in falling edges
// from the first one after the FSM leaves IDLE. At that edge (t=0) the pixel
// position is p = t / CLK_DIV.
// -----------------------------------------------------------------------------
module tb_tft_lcd_timing_gen;

  logic        clk = 1'b0;
  logic        rst_a, enable_a, rst_b, enable_b;
  logic [10:0] counter_h_a, counter_h_b;
  logic [9:0]  counter_v_a, counter_v_b;
  logic        disp_clk_a, disp_den_a, disp_hsync_a, disp_vsync_a, disp_enb_a;
  logic        frame_start_a, busy_a;
  logic        disp_clk_b, disp_den_b, disp_hsync_b, disp_vsync_b, disp_enb_b;
  logic        frame_start_b, busy_b;
`ifdef TFT_TIMING_LINE_IRQ_EN
  logic        line_irq_a, line_irq_b;
  int          irq_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int t;
  int den_cnt, hs_lo_cnt, vs_lo_cnt, fs_cnt, den_b_cnt, fs_b_cnt;

  always #5 clk = ~clk;

  tft_lcd_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(16), .H_SYNC_W(2), .H_DE_START(4), .H_ACTIVE(8),
    .V_TOTAL(8), .V_SYNC_W(1), .V_DE_START(2), .V_ACTIVE(4), .PWR_FRAMES(2)
`ifdef TFT_TIMING_LINE_IRQ_EN
    , .LINE_IRQ(5)
`endif
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .enable(enable_a),
    .counter_h(counter_h_a), .counter_v(counter_v_a),
    .disp_clk(disp_clk_a), .disp_den(disp_den_a),
    .disp_hsync(disp_hsync_a), .disp_vsync(disp_vsync_a),
    .disp_enb(disp_enb_a), .frame_start(frame_start_a), .busy(busy_a)
`ifdef TFT_TIMING_LINE_IRQ_EN
    , .line_irq(line_irq_a)
`endif
  );

  tft_lcd_timing_gen #(
    .CLK_DIV(4), .H_TOTAL(16), .H_SYNC_W(2), .H_DE_START(4), .H_ACTIVE(8),
    .V_TOTAL(8), .V_SYNC_W(1), .V_DE_START(2), .V_ACTIVE(4), .PWR_FRAMES(0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .enable(enable_b),
    .counter_h(counter_h_b), .counter_v(counter_v_b),
    .disp_clk(disp_clk_b), .disp_den(disp_den_b),
    .disp_hsync(disp_hsync_b), .disp_vsync(disp_vsync_b),
    .disp_enb(disp_enb_b), .frame_start(frame_start_b), .busy(busy_b)
`ifdef TFT_TIMING_LINE_IRQ_EN
    , .line_irq(line_irq_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    den_cnt = 0; hs_lo_cnt = 0; vs_lo_cnt = 0; fs_cnt = 0;
    den_b_cnt = 0; fs_b_cnt = 0;
`ifdef TFT_TIMING_LINE_IRQ_EN
    irq_cnt = 0;
`endif
  endtask

  // Advance n falling edges. Each sample is added to the running event counts.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t++;
      if (disp_den_a)    den_cnt++;
      if (!disp_hsync_a) hs_lo_cnt++;
      if (!disp_vsync_a) vs_lo_cnt++;
      if (frame_start_a) fs_cnt++;
      if (disp_den_b)    den_b_cnt++;
      if (frame_start_b) fs_b_cnt++;
`ifdef TFT_TIMING_LINE_IRQ_EN
      if (line_irq_a)    irq_cnt++;
`endif
    end
  endtask

  initial begin
    rst_a = 1'b1; enable_a = 1'b0; rst_b = 1'b1; enable_b = 1'b0;
    t = 0;
    clear_counts();

    // ---- reset state
    @(negedge clk);
    check("rst_counter_h", counter_h_a, 0);
    check("rst_counter_v", counter_v_a, 0);
    check("rst_disp_clk", disp_clk_a, 0);
    check("rst_den", disp_den_a, 0);
    check("rst_hsync", disp_hsync_a, 1);
    check("rst_vsync", disp_vsync_a, 1);
    check("rst_enb", disp_enb_a, 0);
    check("rst_frame_start", frame_start_a, 0);
    check("rst_busy", busy_a, 0);

    rst_a = 1'b0;
    run(2);
    check("idle_busy", busy_a, 0);
    check("idle_disp_clk", disp_clk_a, 0);

    // ---- power-up: enable seen in IDLE, PWR_UP from the next edge
    enable_a = 1'b1;
    @(negedge clk); t = 0;
    check("pu_busy", busy_a, 1);
    check("pu_enb", disp_enb_a, 1);
    check("pu_disp_clk_t0", disp_clk_a, 1);
    check("pu_hsync_t0", disp_hsync_a, 0);
    check("pu_vsync_t0", disp_vsync_a, 0);
    run(1); check("pu_disp_clk_t1", disp_clk_a, 0);
    run(1); check("pu_disp_clk_t2", disp_clk_a, 1);
            check("pu_counter_h_t2", counter_h_a, 1);
    run(1); check("pu_hsync_h1", disp_hsync_a, 0);
    run(1); check("pu_hsync_h2", disp_hsync_a, 1);

    // Two blank frames (t=5..511): no DE, one frame_start at t=256.
    clear_counts();
    run(507);
    check("pu_den_count", den_cnt, 0);
    check("pu_fs_count", fs_cnt, 1);
`ifdef TFT_TIMING_LINE_IRQ_EN
    check("pu_irq_count", irq_cnt, 0);
`endif

    // ---- frame 3 (t=512..767) is the first ACTIVE frame
    run(1);
    check("act_fs_t512", frame_start_a, 1);
    check("act_counter_h_t512", counter_h_a, 0);
    check("act_counter_v_t512", counter_v_a, 0);
    clear_counts();
    run(71);
    check("act_den_h3_v2", disp_den_a, 0);
    run(1);
    check("act_den_h4_v2", disp_den_a, 1);
    check("act_first_de_h", counter_h_a, 4);
    check("act_first_de_v", counter_v_a, 2);
    run(183);
    // Samples t=513..767: 4 lines x 8 px x 2 clk of DE; 2 px x 2 clk of HSYNC
    // low per line, and 1 line x 16 px x 2 clk of VSYNC low, each less the
    // t=512 sample.
    check("act_den_count", den_cnt, 64);
    check("act_hsync_low", hs_lo_cnt, 31);
    check("act_vsync_low", vs_lo_cnt, 31);
    check("act_fs_none", fs_cnt, 0);
`ifdef TFT_TIMING_LINE_IRQ_EN
    check("act_irq_count", irq_cnt, 1);
`endif
    run(1);
    check("act_fs_t768", frame_start_a, 1);

    // ---- drop enable at counter_v=3 of frame 4: lines 3..5 still get DE
    run(96);
    check("dis_at_v3", counter_v_a, 3);
    enable_a = 1'b0;
    clear_counts();
    run(159);
    check("dis_den_tail", den_cnt, 48);
    check("dis_busy", busy_a, 1);
    run(1);
    check("dis_fs_t1024", frame_start_a, 1);
    check("dis_den_off", disp_den_a, 0);
    check("dis_enb_on", disp_enb_a, 1);

    // ---- PWR_DOWN: two blank frames; enable reasserted here must be ignored
    clear_counts();
    run(76);
    enable_a = 1'b1;
    run(435);
    check("pd_den_count", den_cnt, 0);
    check("pd_fs_count", fs_cnt, 1);
    check("pd_enb", disp_enb_a, 1);
    check("pd_busy", busy_a, 1);
`ifdef TFT_TIMING_LINE_IRQ_EN
    check("pd_irq_count", irq_cnt, 0);
`endif
    run(1);
    check("idle_busy2", busy_a, 0);
    check("idle_enb2", disp_enb_a, 0);
    check("idle_counter_h2", counter_h_a, 0);
    check("idle_counter_v2", counter_v_a, 0);
    check("idle_hsync2", disp_hsync_a, 1);
    check("idle_vsync2", disp_vsync_a, 1);
    check("idle_disp_clk2", disp_clk_a, 0);
    run(1);
    check("restart_busy", busy_a, 1);
    check("restart_enb", disp_enb_a, 1);

    // ---- asynchronous reset mid-line
    run(10);
    check("mid_counter_h", counter_h_a, 5);
    check("mid_disp_clk", disp_clk_a, 1);
    rst_a = 1'b1;
    #1;
    check("arst_counter_h", counter_h_a, 0);
    check("arst_disp_clk", disp_clk_a, 0);
    check("arst_hsync", disp_hsync_a, 1);
    check("arst_vsync", disp_vsync_a, 1);
    check("arst_enb", disp_enb_a, 0);
    check("arst_busy", busy_a, 0);
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy_a, 1);
    check("post_rst_counter_h", counter_h_a, 0);
    check("post_rst_disp_clk", disp_clk_a, 1);

    // ---- small config: CLK_DIV=4, PWR_FRAMES=0
    rst_b = 1'b0;
    @(negedge clk);
    enable_b = 1'b1;
    @(negedge clk); t = 0;
    check("b_busy", busy_b, 1);
    check("b_disp_clk_s0", disp_clk_b, 1);
    run(1); check("b_disp_clk_s1", disp_clk_b, 1);
    run(1); check("b_disp_clk_s2", disp_clk_b, 0);
    run(2); check("b_counter_h_s4", counter_h_b, 1);
    run(59);
    check("b_counter_h_s63", counter_h_b, 15);
    check("b_counter_v_s63", counter_v_b, 0);
    run(1);
    check("b_counter_h_wrap", counter_h_b, 0);
    check("b_counter_v_inc", counter_v_b, 1);
    clear_counts();
    run(447);
    check("b_pu_den_count", den_b_cnt, 0);
    check("b_pu_fs_count", fs_b_cnt, 0);
    check("b_counter_h_s511", counter_h_b, 15);
    check("b_counter_v_s511", counter_v_b, 7);
    clear_counts();
    run(1);
    check("b_fs_s512", frame_start_b, 1);
    check("b_counter_v_s512", counter_v_b, 0);
    run(1);
    check("b_fs_s513", frame_start_b, 0);
    run(142);
    check("b_den_h3_v2", disp_den_b, 0);
    run(1);
    check("b_den_h4_v2", disp_den_b, 1);
    check("b_fs_single", fs_b_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
